biriscv_wb_arbiter: RTL and testbench
=====================================

# biriscv_wb_arbiter

Writeback merge stage directly upstream of the 2R1W integer register file. It combines the in-order pipeline writeback (wb0, no backpressure) and the out-of-order long-latency writeback (wb1: load/divide, ready/valid) into the single register-file write port. wb1 results are held in a small buffer while wb0 owns the port. The block also squashes stale buffered results on write-after-write conflicts and reports pending destinations to the issue scoreboard.

## Interface
- DEPTH, 4, wb1 buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a valid buffer head may wait before a stall is requested
- clk_i  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb0_valid_i  in  1  pipeline writeback valid; always accepted
- wb0_rd_i  in  5  pipeline destination register
- wb0_value_i  in  32  pipeline result
- wb1_valid_i  in  1  long-latency writeback valid
- wb1_rd_i  in  5  long-latency destination register
- wb1_value_i  in  32  long-latency result
- wb1_ready_o  out  1  buffer can accept wb1 this cycle
- rd0_o  out  5  register-file write address; 0 means no write
- rd0_value_o  out  32  register-file write data
- pending_o  out  32  bit r set when a live buffered wb1 entry targets xr
- stall_o  out  1  request to the front end to hold wb0 for one or more cycles

## Operation
- Inputs with rd == 0 are dropped at entry. wb0 with rd 0 counts as idle. wb1 with rd 0 completes its handshake but is not stored.
- wb1 handshake: a transfer occurs when wb1_valid_i && wb1_ready_o. wb1_ready_o = (count < DEPTH), from registered count only. A pop in the same cycle does not raise ready.
- Buffer entry: {live, rd, value}. count includes dead entries until they are removed.
- Per-cycle selection, in priority order:
  1. wb0 live: output wb0.
  2. Else buffer head live: output head and pop.
  3. Else buffer empty and wb1 transfer: output wb1 directly (bypass, not stored).
  4. Else rd0_o = 0.
- A dead head is popped silently every cycle, regardless of wb0. A pop of a dead head never produces a write.
- WAW squash: when wb0 is selected with rd X:
  - every live buffer entry with rd X becomes dead;
  - a wb1 transfer with rd X in the same cycle is stored dead.
  - wb1 is defined as older than any concurrent wb0.
- pending_o is the OR of one-hot(rd) over live entries. It is combinational from registered state and does not include the output register.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - increments each cycle a live head is not popped;
  - clears on pop or when the head is dead or absent;
  - stall_o is registered and asserts the cycle after the counter reaches STARVE_LIMIT;
  - stall_o deasserts the cycle after that head pops.
- wb0 valid while stall_o is high is a protocol violation. wb0 still wins. The bench flags it with an assertion.

## Timing
- rd0_o and rd0_value_o are registered: one cycle from selection. The register file captures the write on the following edge.
- Bypass path latency: wb1 transfer at edge N → rd0_o valid after edge N+1. This is the same latency as wb0.
- Buffered entry: it can appear on rd0_o one cycle after push at the earliest.
- Reset values: rd0_o = 0, rd0_value_o = 0, pending_o = 0, stall_o = 0, wb1_ready_o = 1, count = 0, pointers = 0, starvation counter = 0.
- Reset mid-operation discards all buffered entries and any in-flight output write. No write reaches the register file after rst_n falls.
- Full buffer plus wb1_valid_i: no transfer, and wb1 must hold its data.
- Pointer wrap: pointers are clog2(DEPTH) bits with an explicit count, so full and empty are unambiguous.

## Structure
- biriscv_wb_pkg holds:
  - the entry typedef {live, rd[4:0], value[31:0]};
  - REG_ZERO = 5'd0;
  - the XLEN = 32 constant.
- Sub-module biriscv_wb_fifo provides:
  - circular buffer with push, pop and count;
  - a parallel kill-by-rd port;
  - pending-mask generation.
- The top level holds the selection mux, output register, squash decode and starvation counter.

## Test plan
- wb0 x5=0x11 at cycle 0 with wb1 idle → rd0_o=5, rd0_value_o=0x11 at cycle 1; pending_o=0 throughout.
- wb1 x7=0xAA with buffer empty and wb0 idle → bypass: rd0_o=7/0xAA next cycle, never stored, pending_o stays 0.
- wb0 live every cycle while wb1 pushes x1..x4 →
  - wb1_ready_o drops after the fourth push;
  - pending_o=0x1E;
  - stall_o asserts 9 cycles after the first push;
  - when wb0 idles, the 4 results drain in order x1..x4.
- x9 buffered live, then wb0 x9=0x55 selected → x9 entry dead, pending_o bit 9 clears next cycle, only 0x55 is ever written to x9.
- Same-cycle wb0 x3=0x1 and wb1 x3=0x2 → only 0x1 is written; the stored entry is popped dead with no write.
- rst_n low while 3 entries are buffered and rd0_o=4 → all outputs reach reset values immediately; no write after release until new input arrives.

Source files
------------

// File: rtl/biriscv_wb_pkg.sv
// Shared types and constants for the writeback merge stage.
package biriscv_wb_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic            live;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] rd_onehot(input logic [4:0] rd);
    return XLEN'(1) << rd;
  endfunction
endpackage

// File: rtl/biriscv_wb_fifo.sv
// Circular buffer for long-latency writebacks with parallel kill-by-rd
// and a pending-destination mask built from the live entries.
module biriscv_wb_fifo
  import biriscv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  wb_entry_t                  push_entry_i,
  input  logic                       pop_i,
  input  logic                       kill_i,
  input  logic [4:0]                 kill_rd_i,
  output wb_entry_t                  head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [XLEN-1:0]            pending_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  wb_entry_t        entries [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Slots are individual registers so every entry can be killed in parallel;
  // a popped slot is marked dead so free slots never feed the pending mask.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    wb_entry_t entry_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else if (push_i && (wr_ptr_q == PTR_W'(gi))) begin
        entry_q <= push_entry_i;
      end else if (pop_i && (rd_ptr_q == PTR_W'(gi))) begin
        entry_q.live <= 1'b0;
      end else if (kill_i && entry_q.live && (entry_q.rd == kill_rd_i)) begin
        entry_q.live <= 1'b0;
      end
    end

    assign entries[gi] = entry_q;
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].live) pending_o = pending_o | rd_onehot(entries[i].rd);
    end
  end

  assign head_o  = entries[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/biriscv_wb_arbiter.sv
// Merges the in-order (wb0) and long-latency (wb1) writebacks onto the single
// register-file write port, with WAW squash and a starvation stall request.
module biriscv_wb_arbiter
  import biriscv_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            wb0_valid_i,
  input  logic [4:0]      wb0_rd_i,
  input  logic [XLEN-1:0] wb0_value_i,
  input  logic            wb1_valid_i,
  input  logic [4:0]      wb1_rd_i,
  input  logic [XLEN-1:0] wb1_value_i,
  output logic            wb1_ready_o,
  output logic [4:0]      rd0_o,
  output logic [XLEN-1:0] rd0_value_o,
  output logic [XLEN-1:0] pending_o,
  output logic            stall_o
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int STV_W = $clog2(STARVE_LIMIT+1);

  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic [CNT_W-1:0] count;
  logic             wb0_live, wb1_xfer, wb1_keep;
  logic             buf_empty, head_live;
  logic             sel_head, sel_bypass, pop, push;

  logic [4:0]       rd0_q, rd0_d;
  logic [XLEN-1:0]  rd0_value_q, rd0_value_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  assign wb0_live    = wb0_valid_i && (wb0_rd_i != REG_ZERO);
  assign wb1_ready_o = (count < CNT_W'(DEPTH));
  assign wb1_xfer    = wb1_valid_i && wb1_ready_o;
  assign wb1_keep    = wb1_xfer && (wb1_rd_i != REG_ZERO);
  assign buf_empty   = (count == '0);
  assign head_live   = !buf_empty && head.live;

  assign sel_head   = !wb0_live && head_live;
  assign sel_bypass = !wb0_live && buf_empty && wb1_keep;
  assign pop        = !buf_empty && (!head.live || sel_head);
  assign push       = wb1_keep && !sel_bypass;

  // wb1 is the older write, so a same-cycle wb0 to the same rd buries it.
  assign push_entry.live  = !(wb0_live && (wb0_rd_i == wb1_rd_i));
  assign push_entry.rd    = wb1_rd_i;
  assign push_entry.value = wb1_value_i;

  biriscv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (wb0_live),
    .kill_rd_i    (wb0_rd_i),
    .head_o       (head),
    .count_o      (count),
    .pending_o    (pending_o)
  );

  always_comb begin
    rd0_d       = REG_ZERO;
    rd0_value_d = '0;
    if (wb0_live) begin
      rd0_d       = wb0_rd_i;
      rd0_value_d = wb0_value_i;
    end else if (sel_head) begin
      rd0_d       = head.rd;
      rd0_value_d = head.value;
    end else if (sel_bypass) begin
      rd0_d       = wb1_rd_i;
      rd0_value_d = wb1_value_i;
    end
  end

  always_comb begin
    starve_d = '0;
    if (head_live && !pop) begin
      starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
    end
  end

  assign stall_d = head_live && !pop && (starve_q == STV_W'(STARVE_LIMIT));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd0_q       <= REG_ZERO;
      rd0_value_q <= '0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
    end else begin
      rd0_q       <= rd0_d;
      rd0_value_q <= rd0_value_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
    end
  end

  assign rd0_o       = rd0_q;
  assign rd0_value_o = rd0_value_q;
  assign stall_o     = stall_q;
endmodule

// File: tb/tb_biriscv_wb_arbiter.sv
// Directed bench for the writeback merge stage with a write scoreboard.
module tb_biriscv_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb0_valid_i;
  logic [4:0]  wb0_rd_i;
  logic [31:0] wb0_value_i;
  logic        wb1_valid_i;
  logic [4:0]  wb1_rd_i;
  logic [31:0] wb1_value_i;
  logic        wb1_ready_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic [31:0] pending_o;
  logic        stall_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  biriscv_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .wb0_valid_i (wb0_valid_i),
    .wb0_rd_i    (wb0_rd_i),
    .wb0_value_i (wb0_value_i),
    .wb1_valid_i (wb1_valid_i),
    .wb1_rd_i    (wb1_rd_i),
    .wb1_value_i (wb1_value_i),
    .wb1_ready_o (wb1_ready_o),
    .rd0_o       (rd0_o),
    .rd0_value_o (rd0_value_o),
    .pending_o   (pending_o),
    .stall_o     (stall_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] value);
    exp_t e;
    e.rd    = rd;
    e.value = value;
    sb.push_back(e);
    $display("push expected write x%0d=0x%0h", rd, value);
  endtask

  task automatic idle_inputs();
    wb0_valid_i = 1'b0;
    wb0_rd_i    = 5'd0;
    wb0_value_i = 32'd0;
    wb1_valid_i = 1'b0;
    wb1_rd_i    = 5'd0;
    wb1_value_i = 32'd0;
  endtask

  task automatic drive_wb0(input logic [4:0] rd, input logic [31:0] value);
    wb0_valid_i = 1'b1;
    wb0_rd_i    = rd;
    wb0_value_i = value;
  endtask

  task automatic drive_wb1(input logic [4:0] rd, input logic [31:0] value);
    wb1_valid_i = 1'b1;
    wb1_rd_i    = rd;
    wb1_value_i = value;
  endtask

  // Register-file side: every write is matched against the scoreboard in order.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1) begin
      check("proto_wb0_during_stall", 64'(stall_o && wb0_valid_i), 64'd0);
      if (rd0_o != 5'd0) begin
        $display("write x%0d=0x%0h", rd0_o, rd0_value_o);
        if (sb.size() == 0) begin
          check("unexpected_write_rd", 64'(rd0_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check("write_rd", 64'(rd0_o), 64'(e.rd));
          check("write_value", 64'(rd0_value_o), 64'(e.value));
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset_rd0", 64'(rd0_o), 64'd0);
    check("reset_value", 64'(rd0_value_o), 64'd0);
    check("reset_pending", 64'(pending_o), 64'd0);
    check("reset_stall", 64'(stall_o), 64'd0);
    check("reset_ready", 64'(wb1_ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain pipeline writeback
    drive_wb0(5'd5, 32'h11);
    expect_write(5'd5, 32'h11);
    tick();
    check("t1_rd0", 64'(rd0_o), 64'd5);
    check("t1_value", 64'(rd0_value_o), 64'h11);
    check("t1_pending", 64'(pending_o), 64'd0);
    idle_inputs();
    tick();
    check("t1_idle_rd0", 64'(rd0_o), 64'd0);

    // Bypass into an empty buffer
    check("t2_ready", 64'(wb1_ready_o), 64'd1);
    drive_wb1(5'd7, 32'hAA);
    expect_write(5'd7, 32'hAA);
    tick();
    check("t2_rd0", 64'(rd0_o), 64'd7);
    check("t2_value", 64'(rd0_value_o), 64'hAA);
    check("t2_pending", 64'(pending_o), 64'd0);
    idle_inputs();
    tick();
    check("t2_idle_rd0", 64'(rd0_o), 64'd0);
    check("t2_idle_pending", 64'(pending_o), 64'd0);

    // Fill the buffer under continuous wb0, then watch the stall and drain
    for (int c = 0; c < 10; c++) begin
      drive_wb0(5'(10 + c), 32'h100 + 32'(c));
      expect_write(5'(10 + c), 32'h100 + 32'(c));
      if (c < 4) drive_wb1(5'(c + 1), 32'hA1 + 32'(c));
      else       drive_wb1(5'd20, 32'hBB);
      tick();
      check("t3_ready", 64'(wb1_ready_o), 64'(c < 3));
      check("t3_stall", 64'(stall_o), 64'(c == 9));
      if (c >= 3) check("t3_pending", 64'(pending_o), 64'h1E);
    end
    wb0_valid_i = 1'b0;
    wb0_rd_i    = 5'd0;
    for (int k = 1; k <= 4; k++) expect_write(5'(k), 32'hA0 + 32'(k));
    expect_write(5'd20, 32'hBB);
    check("t3_full_ready", 64'(wb1_ready_o), 64'd0);
    tick();
    check("t3_drain_rd0_1", 64'(rd0_o), 64'd1);
    check("t3_stall_release", 64'(stall_o), 64'd0);
    check("t3_ready_back", 64'(wb1_ready_o), 64'd1);
    tick();
    wb1_valid_i = 1'b0;
    check("t3_drain_rd0_2", 64'(rd0_o), 64'd2);
    check("t3_pending_late", 64'(pending_o), 64'h0010_0018);
    tick();
    check("t3_drain_rd0_3", 64'(rd0_o), 64'd3);
    tick();
    check("t3_drain_rd0_4", 64'(rd0_o), 64'd4);
    tick();
    check("t3_drain_rd0_20", 64'(rd0_o), 64'd20);
    idle_inputs();
    tick();
    check("t3_empty_rd0", 64'(rd0_o), 64'd0);
    check("t3_empty_pending", 64'(pending_o), 64'd0);

    // Buffered x9 squashed by a later wb0 to x9
    drive_wb0(5'd11, 32'h77);
    drive_wb1(5'd9, 32'h99);
    expect_write(5'd11, 32'h77);
    tick();
    check("t4_pending_set", 64'(pending_o), 64'h200);
    idle_inputs();
    drive_wb0(5'd9, 32'h55);
    expect_write(5'd9, 32'h55);
    tick();
    check("t4_rd0", 64'(rd0_o), 64'd9);
    check("t4_value", 64'(rd0_value_o), 64'h55);
    check("t4_pending_clear", 64'(pending_o), 64'd0);
    idle_inputs();
    tick();
    check("t4_dead_pop_rd0", 64'(rd0_o), 64'd0);
    tick();
    check("t4_after_rd0", 64'(rd0_o), 64'd0);
    check("t4_ready", 64'(wb1_ready_o), 64'd1);

    // Same-cycle WAW: wb0 wins, wb1 stored dead
    drive_wb0(5'd3, 32'h1);
    drive_wb1(5'd3, 32'h2);
    expect_write(5'd3, 32'h1);
    tick();
    check("t5_rd0", 64'(rd0_o), 64'd3);
    check("t5_value", 64'(rd0_value_o), 64'h1);
    check("t5_pending", 64'(pending_o), 64'd0);
    idle_inputs();
    tick();
    check("t5_dead_pop_rd0", 64'(rd0_o), 64'd0);
    tick();
    check("t5_after_rd0", 64'(rd0_o), 64'd0);

    // Reset with three entries buffered and a write in flight
    drive_wb0(5'd20, 32'h200);
    drive_wb1(5'd5, 32'h5);
    expect_write(5'd20, 32'h200);
    tick();
    drive_wb0(5'd21, 32'h201);
    drive_wb1(5'd6, 32'h6);
    expect_write(5'd21, 32'h201);
    tick();
    drive_wb0(5'd4, 32'h44);
    drive_wb1(5'd7, 32'h7);
    tick();
    check("t6_rd0_before", 64'(rd0_o), 64'd4);
    check("t6_pending_before", 64'(pending_o), 64'hE0);
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd0", 64'(rd0_o), 64'd0);
    check("t6_rst_value", 64'(rd0_value_o), 64'd0);
    check("t6_rst_pending", 64'(pending_o), 64'd0);
    check("t6_rst_stall", 64'(stall_o), 64'd0);
    check("t6_rst_ready", 64'(wb1_ready_o), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_post_rd0", 64'(rd0_o), 64'd0);
      check("t6_post_pending", 64'(pending_o), 64'd0);
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
